// File: rtl/pll_dyn_pkg.sv
// PLL dynamic-reconfiguration shared types.
// Profile table and divider-to-DYN-port encodings.
package pll_dyn_pkg;

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_state_e;

  typedef struct packed {
    logic [5:0] idiv;
    logic [5:0] fbdiv;
    logic [6:0] mdiv;
    logic [6:0] odiv0;
  } pll_prof_t;

  // 50 MHz * 102 / 6 / 6 = 141.67 MHz (x17/6)
  localparam pll_prof_t PROF_0 = '{
    idiv:  6'd6,
    fbdiv: 6'd1,
    mdiv:  7'd102,
    odiv0: 7'd6
  };

  // 50 MHz * 100 / 7 / 5 = 142.86 MHz (x20/7)
  localparam pll_prof_t PROF_1 = '{
    idiv:  6'd7,
    fbdiv: 6'd1,
    mdiv:  7'd100,
    odiv0: 7'd5
  };

  // Slots above 1 fall back to the safe profile 0.
  function automatic pll_prof_t prof_lookup(
    input logic [2:0] idx
  );
    pll_prof_t p;
    unique case (idx)
      3'd1:    p = PROF_1;
      default: p = PROF_0;
    endcase
    return p;
  endfunction

  // DYN ports take the two's-complement of the divider.
  function automatic logic [5:0] enc6(
    input logic [5:0] d
  );
    return 6'd0 - d;
  endfunction

  function automatic logic [6:0] enc7(
    input logic [6:0] d
  );
    return 7'd0 - d;
  endfunction

endpackage

// File: rtl/pll_dyn_ctrl_lock_sync.sv
// Two-flop synchroniser for the PLL lock flag.
// Output lags the input by two clk cycles.
module lock_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the async lock through two flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL reset/lock sequencer with profile switching.
// Retries lock, gates system reset, parks in FAIL.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int NUM_PROFILES     = 2,
  parameter int DEFAULT_PROFILE  = 0,
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRIES      = 3,
  localparam int PW =
    (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [PW-1:0] profile_sel,
  input  logic          switch_req,
  output logic          switch_ack,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    idsel,
  output logic [5:0]    fbdsel,
  output logic [6:0]    mdsel,
  output logic [6:0]    odsel0,
  output logic          sys_reset_n,
  output logic [PW-1:0] active_profile,
  output logic          busy,
  output logic          fail
);

  localparam int CM0 =
    (LOCK_TIMEOUT_CYC > LOCK_STABLE_CYC) ?
    LOCK_TIMEOUT_CYC : LOCK_STABLE_CYC;
  localparam int CMAX =
    (CM0 > PLL_RST_CYC) ? CM0 : PLL_RST_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int RW =
    (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CW-1:0] RST_LAST =
    CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STB_LAST =
    CW'(LOCK_STABLE_CYC - 1);

  pll_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic          pend_q, pend_d;
  logic [PW-1:0] prof_q, prof_d;
  logic          lock_s;
  logic          sel_ok;
  pll_prof_t     prof;

  lock_sync u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pll_lock),
    .q_o     (lock_s)
  );

  assign sel_ok = switch_req &&
    (32'(profile_sel) < NUM_PROFILES);

  assign cnt_inc = (cnt_q == '1) ?
    cnt_q : cnt_q + 1'b1;
  assign retry_inc = (retry_q == '1) ?
    retry_q : retry_q + 1'b1;

  // Sequencer next-state, counters and profile latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    pend_d  = pend_q;
    prof_d  = prof_q;
    unique case (state_q)
      RST_PLL: begin
        if (cnt_q >= RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          // this locked cycle opens the window
          state_d = STABLE;
          cnt_d   = CW'(1);
        end else if (cnt_q >= TMO_LAST) begin
          cnt_d   = '0;
          retry_d = retry_inc;
          if (int'(retry_q) + 1 < MAX_RETRIES) begin
            state_d = RST_PLL;
          end else begin
            state_d = FAIL;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q >= STB_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        retry_d = '0;
        pend_d  = 1'b0;
        if (sel_ok) begin
          prof_d  = profile_sel;
          pend_d  = 1'b1;
          state_d = RST_PLL;
          cnt_d   = '0;
        end else if (!lock_s) begin
          state_d = RST_PLL;
          cnt_d   = '0;
        end
      end
      FAIL: begin
        if (sel_ok) begin
          prof_d  = profile_sel;
          retry_d = '0;
          pend_d  = 1'b1;
          state_d = RST_PLL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RST_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_PLL;
      cnt_q   <= '0;
      retry_q <= '0;
      pend_q  <= 1'b0;
      prof_q  <= PW'(DEFAULT_PROFILE);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pend_q  <= pend_d;
      prof_q  <= prof_d;
    end
  end

  assign prof = prof_lookup(3'(prof_q));

  assign idsel  = enc6(prof.idiv);
  assign fbdsel = enc6(prof.fbdiv);
  assign mdsel  = enc7(prof.mdiv);
  assign odsel0 = enc7(prof.odiv0);

  assign pll_reset = (state_q == RST_PLL) ||
                     (state_q == FAIL);
  assign sys_reset_n    = (state_q == RUN);
  assign busy           = (state_q != RUN) &&
                          (state_q != FAIL);
  assign fail           = (state_q == FAIL);
  assign switch_ack     = (state_q == RUN) && pend_q;
  assign active_profile = prof_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Bench for pll_dyn_ctrl: directed tables,
// hand sequences and a randomized reference model.
module tb_pll_dyn_ctrl;

  localparam int NP  = 5;
  localparam int PRC = 4;
  localparam int TMO = 32;
  localparam int STB = 8;
  localparam int MR  = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] profile_sel = '0;
  logic       switch_req = 1'b0;
  logic       pll_lock = 1'b0;
  logic       switch_ack;
  logic       pll_reset;
  logic [5:0] idsel;
  logic [5:0] fbdsel;
  logic [6:0] mdsel;
  logic [6:0] odsel0;
  logic       sys_reset_n;
  logic [2:0] active_profile;
  logic       busy;
  logic       fail;

  always #5 clk = ~clk;

  pll_dyn_ctrl #(
    .NUM_PROFILES     (NP),
    .DEFAULT_PROFILE  (0),
    .PLL_RST_CYC      (PRC),
    .LOCK_TIMEOUT_CYC (TMO),
    .LOCK_STABLE_CYC  (STB),
    .MAX_RETRIES      (MR)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .profile_sel    (profile_sel),
    .switch_req     (switch_req),
    .switch_ack     (switch_ack),
    .pll_lock       (pll_lock),
    .pll_reset      (pll_reset),
    .idsel          (idsel),
    .fbdsel         (fbdsel),
    .mdsel          (mdsel),
    .odsel0         (odsel0),
    .sys_reset_n    (sys_reset_n),
    .active_profile (active_profile),
    .busy           (busy),
    .fail           (fail)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d want %0d at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // Divider values of each profile (x17/6, x20/7).
  function automatic int div_i(input int p);
    return (p == 1) ? 7 : 6;
  endfunction
  function automatic int div_m(input int p);
    return (p == 1) ? 100 : 102;
  endfunction
  function automatic int div_o(input int p);
    return (p == 1) ? 5 : 6;
  endfunction

  // Reference model: phase plus elapsed time.
  typedef enum int {
    P_RESET, P_WAIT, P_STAB, P_RUN, P_FAIL
  } ph_t;

  ph_t m_ph;
  int  m_el, m_fails, m_run, m_prof;
  bit  m_pend, m_ack, m_s1, m_s2;

  task automatic model_reset();
    m_ph = P_RESET;
    m_el = 0;
    m_fails = 0;
    m_run = 0;
    m_prof = 0;
    m_pend = 0;
    m_ack = 0;
    m_s1 = 0;
    m_s2 = 0;
  endtask

  task automatic model_step(
    input bit lk, input bit sr, input int sel
  );
    bit ok;
    bit nack;
    ok = sr && (sel < NP);
    nack = 0;
    case (m_ph)
      P_RESET: begin
        m_el++;
        if (m_el == PRC) begin
          m_ph = P_WAIT;
          m_el = 0;
        end
      end
      P_WAIT: begin
        if (m_s2) begin
          m_ph = P_STAB;
          m_run = 1;
        end else begin
          m_el++;
          if (m_el == TMO) begin
            m_el = 0;
            m_fails++;
            m_ph = (m_fails < MR) ? P_RESET : P_FAIL;
          end
        end
      end
      P_STAB: begin
        if (!m_s2) begin
          m_ph = P_WAIT;
          m_el = 0;
        end else begin
          m_run++;
          if (m_run == STB) begin
            m_ph = P_RUN;
            nack = m_pend;
            m_pend = 0;
          end
        end
      end
      P_RUN: begin
        m_fails = 0;
        if (ok) begin
          m_prof = sel;
          m_pend = 1;
          m_ph = P_RESET;
          m_el = 0;
        end else if (!m_s2) begin
          m_ph = P_RESET;
          m_el = 0;
        end
      end
      default: begin
        if (ok) begin
          m_prof = sel;
          m_fails = 0;
          m_pend = 1;
          m_ph = P_RESET;
          m_el = 0;
        end
      end
    endcase
    m_ack = nack;
    m_s2 = m_s1;
    m_s1 = lk;
  endtask

  task automatic check_model();
    chk("m pll_reset", pll_reset,
        32'(m_ph == P_RESET || m_ph == P_FAIL));
    chk("m sys_reset_n", sys_reset_n,
        32'(m_ph == P_RUN));
    chk("m busy", busy,
        32'(!(m_ph == P_RUN || m_ph == P_FAIL)));
    chk("m fail", fail, 32'(m_ph == P_FAIL));
    chk("m switch_ack", switch_ack, 32'(m_ack));
    chk("m active", active_profile, m_prof);
    chk("m idsel", idsel, 64 - div_i(m_prof));
    chk("m fbdsel", fbdsel, 64 - 1);
    chk("m mdsel", mdsel, 128 - div_m(m_prof));
    chk("m odsel0", odsel0, 128 - div_o(m_prof));
  endtask

  task automatic cyc(
    input bit lk, input bit sr, input logic [2:0] sel
  );
    pll_lock = lk;
    switch_req = sr;
    profile_sel = sel;
    @(posedge clk);
    if (reset_n) model_step(lk, sr, int'(sel));
    else model_reset();
    #1;
    switch_req = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pll_lock = 1'b0;
    switch_req = 1'b0;
    #1;
    model_reset();
    chk("rst pll_reset", pll_reset, 1);
    chk("rst sys_reset_n", sys_reset_n, 0);
    chk("rst busy", busy, 1);
    chk("rst fail", fail, 0);
    chk("rst switch_ack", switch_ack, 0);
    chk("rst active", active_profile, 0);
    chk("rst idsel", idsel, 58);
    chk("rst fbdsel", fbdsel, 63);
    chk("rst mdsel", mdsel, 26);
    chk("rst odsel0", odsel0, 122);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit lk;
    bit prst;
    bit srn;
    bit bsy;
    bit fl;
  } vec_t;

  vec_t vec[$];

  task automatic run_vec(input string nm);
    for (int c = 0; c < vec.size(); c++) begin
      chk($sformatf("%s c%0d pll_reset", nm, c),
          pll_reset, vec[c].prst);
      chk($sformatf("%s c%0d sys_reset_n", nm, c),
          sys_reset_n, vec[c].srn);
      chk($sformatf("%s c%0d busy", nm, c),
          busy, vec[c].bsy);
      chk($sformatf("%s c%0d fail", nm, c),
          fail, vec[c].fl);
      cyc(vec[c].lk, 0, 0);
    end
  endtask

  task automatic run_to_run(
    input string nm, input int want_acks
  );
    int acks;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 0);
      if (switch_ack) acks++;
    end
    chk({nm, " ack count"}, acks, want_acks);
    chk({nm, " in run"}, sys_reset_n, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int hold;
    bit lk;
    #12;

    // Lock rises in cycle 10; release 8 after sync.
    do_reset();
    vec.delete();
    for (int c = 0; c < 25; c++)
      vec.push_back('{lk: (c >= 10), prst: (c < 4),
                      srn: (c >= 20), bsy: (c < 20),
                      fl: 1'b0});
    run_vec("lockup");

    // Switch to profile 1 from RUN.
    cyc(1, 1, 3'd1);
    chk("sw pll_reset", pll_reset, 1);
    chk("sw sys_reset_n", sys_reset_n, 0);
    chk("sw active", active_profile, 1);
    chk("sw idsel", idsel, 57);
    chk("sw mdsel", mdsel, 28);
    chk("sw odsel0", odsel0, 123);
    run_to_run("sw", 1);

    // Out-of-range profile is ignored.
    cyc(1, 1, 3'd5);
    chk("bad sel sys_reset_n", sys_reset_n, 1);
    chk("bad sel active", active_profile, 1);
    chk("bad sel pll_reset", pll_reset, 0);
    cyc(1, 0, 0);
    chk("bad sel ack", switch_ack, 0);

    // Reset while STABLE after a switch.
    cyc(1, 1, 3'd1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0);
    chk("stab busy", busy, 1);
    chk("stab pll_reset", pll_reset, 0);
    chk("stab sys_reset_n", sys_reset_n, 0);
    chk("stab active", active_profile, 1);
    do_reset();

    // No lock: two timeouts then FAIL.
    vec.delete();
    for (int c = 0; c < 100; c++)
      vec.push_back('{lk: 1'b0,
        prst: (c < 4) || (c >= 36 && c < 40) || (c >= 72),
        srn: 1'b0, bsy: (c < 72), fl: (c >= 72)});
    run_vec("nolock");
    cyc(1, 1, 3'd1);
    chk("fail exit fail", fail, 0);
    chk("fail exit pll_reset", pll_reset, 1);
    chk("fail exit active", active_profile, 1);
    run_to_run("fail exit", 1);

    // Three-cycle lock glitch during STABLE.
    do_reset();
    vec.delete();
    for (int c = 0; c < 25; c++)
      vec.push_back('{lk: !(c >= 6 && c <= 8),
                      prst: (c < 4), srn: (c >= 19),
                      bsy: (c < 19), fl: 1'b0});
    run_vec("glitch");

    // Switch request during WAIT_LOCK is ignored.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(0, 0, 0);
    cyc(0, 1, 3'd1);
    chk("wait sw active", active_profile, 0);
    chk("wait sw busy", busy, 1);
    run_to_run("wait sw", 0);
    chk("wait sw active end", active_profile, 0);

    // Random lock and requests against the model.
    hold = 0;
    lk = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        lk = ($urandom_range(0, 3) != 0);
        if (lk) hold = $urandom_range(1, 60);
        else if ($urandom_range(0, 5) == 0)
          hold = $urandom_range(30, 80);
        else hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cyc(lk, ($urandom_range(0, 15) == 0),
            3'($urandom_range(0, 7)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
